switch_box_cfg: RTL

Parametrised, runtime-configurable switch box for the FPGA routing fabric. It replaces the fixed tristate `inout` matrix with explicit per-pin in/out/oe ports, and adds a handshaked configuration loader with double-buffered (shadow/active) routing tables. A new table is loaded word-by-word without disturbing live routing. All pins then switch atomically on a single commit edge.

---
 rtl/switch_box_pkg.sv | 87 ++++++++
 rtl/switch_box_pin_mux.sv | 41 ++++
 rtl/switch_box_cfg.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/switch_box_pkg.sv
`default_nettype none
// ============================================================================
// switch_box_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the configurable switch box:
//   - side codes carried in the low 3 bits of a config word
//   - loader FSM state encoding
//   - clog2 helper usable in constant expressions
//   - (side, idx) -> flat pin number mapping and word legality check
// Pin numbering: top, then right, then bottom, then left.
// Revision: 1.0 - initial release
// ============================================================================
package switch_box_pkg;

  localparam logic [2:0] SIDE_OFF    = 3'd0;
  localparam logic [2:0] SIDE_TOP    = 3'd1;
  localparam logic [2:0] SIDE_RIGHT  = 3'd2;
  localparam logic [2:0] SIDE_BOTTOM = 3'd3;
  localparam logic [2:0] SIDE_LEFT   = 3'd4;

  // Width of the flat pin number returned by map_pin; generous for any
  // practical switch box size.
  localparam int PIN_NUM_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } cfg_state_t;

  typedef struct packed {
    logic                 valid;
    logic [PIN_NUM_W-1:0] pin;
  } pin_sel_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Flat pin number for (side, idx). valid is cleared for side off,
  // illegal side codes and idx beyond the side width.
  function automatic pin_sel_t map_pin(input logic [2:0] side, input int idx,
                                       input int w_tb, input int w_lr);
    pin_sel_t sel;
    sel = '0;
    case (side)
      SIDE_TOP: begin
        sel.valid = (idx < w_tb);
        sel.pin   = PIN_NUM_W'(idx);
      end
      SIDE_RIGHT: begin
        sel.valid = (idx < w_lr);
        sel.pin   = PIN_NUM_W'(w_tb + idx);
      end
      SIDE_BOTTOM: begin
        sel.valid = (idx < w_tb);
        sel.pin   = PIN_NUM_W'(w_tb + w_lr + idx);
      end
      SIDE_LEFT: begin
        sel.valid = (idx < w_lr);
        sel.pin   = PIN_NUM_W'(2 * w_tb + w_lr + idx);
      end
      default: sel = '0;
    endcase
    return sel;
  endfunction

  // A word is legal if it is "off" (any idx) or names an existing pin.
  function automatic logic word_legal(input logic [2:0] side, input int idx,
                                      input int w_tb, input int w_lr);
    logic ok;
    case (side)
      SIDE_OFF:                ok = 1'b1;
      SIDE_TOP, SIDE_BOTTOM:   ok = (idx < w_tb);
      SIDE_RIGHT, SIDE_LEFT:   ok = (idx < w_lr);
      default:                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/switch_box_pin_mux.sv
`default_nettype none
// ============================================================================
// switch_box_pin_mux
// ----------------------------------------------------------------------------
// Decodes one active routing word for pin PIN and selects its source.
// Ports:
//   cfg_word  in  [CFG_W-1:0]  {idx, side} routing word for this pin
//   pin_in    in  [N_PINS-1:0] values present on all fabric pins
//   out       out              routed value (0 when not driving)
//   oe        out              drive enable for this pin
// Revision: 1.0 - initial release
// ============================================================================
module switch_box_pin_mux
  import switch_box_pkg::*;
#(
  parameter int W_TB   = 5,
  parameter int W_LR   = 4,
  parameter int CFG_W  = 6,
  parameter int N_PINS = 18,
  parameter int PIN    = 0
) (
  input  logic [CFG_W-1:0]  cfg_word,
  input  logic [N_PINS-1:0] pin_in,
  output logic              out,
  output logic              oe
);

  pin_sel_t sel;

  always_comb begin
    sel = map_pin(cfg_word[2:0], 32'(cfg_word[CFG_W-1:3]), W_TB, W_LR);
    // A self-route would form a trivial loop; treat it as off.
    oe  = sel.valid && (sel.pin != PIN_NUM_W'(PIN));
    out = 1'b0;
    for (int i = 0; i < N_PINS; i++) begin
      if (oe && (sel.pin == PIN_NUM_W'(i))) out = pin_in[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/switch_box_cfg.sv
`default_nettype none
// ============================================================================
// switch_box_cfg
// ----------------------------------------------------------------------------
// Runtime-configurable fabric switch box with a handshaked loader and
// double-buffered routing tables. Words are written into a shadow table
// while the active table keeps routing; all pins switch together on the
// single commit edge.
// Ports:
//   clk, rst_n   in   clock, asynchronous active-low reset
//   pin_in       in   [N_PINS-1:0] values present on the fabric pins
//   pin_out      out  [N_PINS-1:0] values driven onto the pins
//   pin_oe       out  [N_PINS-1:0] per-pin drive enable
//   cfg_start    in   begin / restart a table load
//   cfg_valid    in   cfg_data valid
//   cfg_data     in   [CFG_W-1:0] {idx, side} word for pin cnt
//   cfg_ready    out  loader accepts a word this cycle
//   cfg_done     out  one-cycle pulse in the commit cycle
//   cfg_err      out  sticky: illegal word seen in current load
// Revision: 1.0 - initial release
// ============================================================================
module switch_box_cfg
  import switch_box_pkg::*;
#(
  parameter  int W_TB    = 5,
  parameter  int W_LR    = 4,
  parameter  int REG_OUT = 0,
  localparam int N_PINS  = 2 * W_TB + 2 * W_LR,
  localparam int IDX_RAW = clog2((W_TB > W_LR) ? W_TB : W_LR),
  localparam int IDX_W   = (IDX_RAW < 1) ? 1 : IDX_RAW,
  localparam int CFG_W   = IDX_W + 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_PINS-1:0] pin_in,
  output logic [N_PINS-1:0] pin_out,
  output logic [N_PINS-1:0] pin_oe,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic [CFG_W-1:0]  cfg_data,
  output logic              cfg_ready,
  output logic              cfg_done,
  output logic              cfg_err
);

  localparam int              CNT_W    = clog2(N_PINS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PINS - 1);

  cfg_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             restart;
  logic             accept;
  logic             word_bad;

  logic [N_PINS-1:0] route_out;
  logic [N_PINS-1:0] route_oe;

  // --------------------------------------------------------------------------
  // Loader FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    cfg_done  = 1'b0;
    restart   = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_start) begin
          restart   = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cfg_ready = 1'b1;
        // A restart in the same cycle as a valid word wins; the word is dropped.
        if (cfg_start) begin
          restart = 1'b1;
        end else if (cfg_valid) begin
          accept = 1'b1;
          if (cnt == LAST_CNT) state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        cfg_done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Word counter and sticky error flag
  // --------------------------------------------------------------------------
  always_comb begin
    word_bad = !word_legal(cfg_data[2:0], 32'(cfg_data[CFG_W-1:3]), W_TB, W_LR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      cfg_err <= 1'b0;
    end else if (restart) begin
      cnt     <= '0;
      cfg_err <= 1'b0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
      if (word_bad) cfg_err <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-pin shadow/active entries and source mux
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N_PINS; i++) begin : g_entry
    logic [CFG_W-1:0] shadow_q;
    logic [CFG_W-1:0] act_q;

    // Illegal words are stored as-is; the pin mux decodes them as off.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                               shadow_q <= '0;
      else if (accept && (cnt == CNT_W'(i)))    shadow_q <= cfg_data;
    end

    // Every entry copies on the same edge, so the table switches atomically.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        act_q <= '0;
      else if (cfg_done) act_q <= shadow_q;
    end

    switch_box_pin_mux #(
      .W_TB   (W_TB),
      .W_LR   (W_LR),
      .CFG_W  (CFG_W),
      .N_PINS (N_PINS),
      .PIN    (i)
    ) u_mux (
      .cfg_word (act_q),
      .pin_in   (pin_in),
      .out      (route_out[i]),
      .oe       (route_oe[i])
    );
  end

  // --------------------------------------------------------------------------
  // Optional output register
  // --------------------------------------------------------------------------
  if (REG_OUT != 0) begin : g_reg_out
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pin_out <= '0;
        pin_oe  <= '0;
      end else begin
        pin_out <= route_out;
        pin_oe  <= route_oe;
      end
    end
  end else begin : g_comb_out
    assign pin_out = route_out;
    assign pin_oe  = route_oe;
  end

endmodule
`default_nettype wire
